// File: rtl/lsu_mem_initiator_if.sv
// Word-addressed, byte-strobed request/ready bus between the LSU and the data RAM.
interface lsu_mem_initiator_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: computes rs1+imm, checks alignment, runs one memory
// handshake with a timeout, and returns extended load data.
module lsu_mem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  lsu_mem_initiator_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [31:0] eff_q, eff_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] load_data_q, load_data_d;

  logic [31:0] eff_addr;
  logic        legal;
  logic [1:0]  off_q;
  logic [16:0] tcnt_inc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  assign eff_addr = rs1 + imm;
  assign off_q    = eff_q[1:0];
  assign tcnt_inc = {1'b0, tcnt_q} + 17'd1;

  always_comb begin
    unique case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~eff_addr[0];
      3'b010:  legal = (eff_addr[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~eff_addr[0];
      default: legal = 1'b0;
    endcase
  end

  assign rd_byte = mem.mem_rdata[8*off_q +: 8];
  assign rd_half = mem.mem_rdata[16*off_q[1] +: 16];

  always_comb begin
    unique case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    eff_d       = eff_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    rs2_d       = rs2_q;
    load_data_d = load_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          eff_d      = eff_addr;
          is_store_d = is_store;
          funct3_d   = funct3;
          rs2_d      = rs2_data;
          tcnt_d     = '0;
          state_d    = legal ? REQ : ERR;
        end
      end
      REQ: begin
        // A ready in the same cycle as the timeout hit still wins.
        if (mem.mem_ready) begin
          if (!is_store_q) load_data_d = rd_ext;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_inc[15:0];
          if (tcnt_inc == 17'(TIMEOUT)) state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      eff_q       <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      rs2_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      eff_q       <= eff_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      rs2_q       <= rs2_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    unique case (funct3_q[1:0])
      2'b00: begin
        mem.mem_wstrb = 4'b0001 << off_q;
        mem.mem_wdata = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        mem.mem_wstrb = 4'b0011 << off_q;
        mem.mem_wdata = {2{rs2_q[15:0]}};
      end
      default: begin
        mem.mem_wstrb = 4'b1111;
        mem.mem_wdata = rs2_q;
      end
    endcase
    if (!is_store_q) mem.mem_wstrb = 4'b0000;
  end

  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_we   = is_store_q;
  assign mem.mem_addr = eff_q[31:2];

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: vector table plus start-while-busy and reset-mid-access sequences.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] rs1, imm, rs2_data;
  logic        busy, done, err;
  logic [31:0] load_data;

  lsu_mem_initiator_if mem_if ();

  lsu_mem_initiator #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .rs1       (rs1),
    .imm       (imm),
    .rs2_data  (rs2_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .mem       (mem_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    int          k;       // REQ cycles before ready; 99 = never
    logic [31:0] rd;
    logic        e_err;
    int          e_cyc;   // cycle of done/err pulse
    int          e_req;   // cycles with mem_req high
    logic [29:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
  } vec_t;

  int          r_done, r_err, r_req, r_idle;
  logic [29:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata, r_ld;
  logic        r_we;

  task automatic run_cmd(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] d, input int k,
                         input logic [31:0] rd);
    is_store = st; funct3 = f3; rs1 = a; imm = b; rs2_data = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r_done = -1; r_err = -1; r_req = 0; r_idle = -1;
    r_addr = '0; r_wstrb = '0; r_wdata = '0; r_we = 1'b0; r_ld = '0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_if.mem_req) begin
        if (r_req == 0) begin
          r_addr = mem_if.mem_addr; r_wstrb = mem_if.mem_wstrb;
          r_wdata = mem_if.mem_wdata; r_we = mem_if.mem_we;
        end
        mem_if.mem_ready = (r_req == k);
        mem_if.mem_rdata = rd;
        r_req++;
      end else begin
        mem_if.mem_ready = 1'b0;
      end
      if (done) begin r_done = c; r_ld = load_data; end
      if (err)  begin r_err = c;  r_ld = load_data; end
      if (!busy) begin r_idle = c; break; end
      @(posedge clk); #1;
    end
    mem_if.mem_ready = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    int   nreq, ndone, nerr;
    logic addr_ok;

    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 3, 32'hDEADBEEF, 1'b0, 5, 4, 30'h41, 4'b0000, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 0, 32'h80123456, 1'b0, 2, 1, 30'h80, 4'b0000, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 0, 32'h80123456, 1'b0, 2, 1, 30'h80, 4'b0000, 32'h0, 32'h00000080};
    vecs[3]  = '{1'b0, 3'b001, 32'h200, 32'h2, 32'h0, 0, 32'h80010000, 1'b0, 2, 1, 30'h80, 4'b0000, 32'h0, 32'hFFFF8001};
    vecs[4]  = '{1'b0, 3'b101, 32'h1FC, 32'h6, 32'h0, 1, 32'h80010000, 1'b0, 3, 2, 30'h80, 4'b0000, 32'h0, 32'h00008001};
    vecs[5]  = '{1'b1, 3'b000, 32'h100, 32'h1, 32'hAB, 0, 32'h0, 1'b0, 2, 1, 30'h40, 4'b0010, 32'hABABABAB, 32'h00008001};
    vecs[6]  = '{1'b1, 3'b001, 32'h104, 32'hFFFFFFFE, 32'h1234, 2, 32'h0, 1'b0, 4, 3, 30'h40, 4'b1100, 32'h12341234, 32'h00008001};
    vecs[7]  = '{1'b1, 3'b010, 32'h10, 32'hC, 32'hCAFEF00D, 0, 32'h0, 1'b0, 2, 1, 30'h7, 4'b1111, 32'hCAFEF00D, 32'h00008001};
    vecs[8]  = '{1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 0, 32'h0, 1'b1, 1, 0, 30'h0, 4'b0000, 32'h0, 32'h00008001};
    vecs[9]  = '{1'b1, 3'b001, 32'h100, 32'h3, 32'h55, 0, 32'h0, 1'b1, 1, 0, 30'h0, 4'b0000, 32'h0, 32'h00008001};
    vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 0, 30'h0, 4'b0000, 32'h0, 32'h00008001};
    vecs[11] = '{1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 0, 30'h0, 4'b0000, 32'h0, 32'h00008001};
    vecs[12] = '{1'b0, 3'b010, 32'h0, 32'h20, 32'h0, 99, 32'h0, 1'b1, 5, 4, 30'h8, 4'b0000, 32'h0, 32'h00008001};
    vecs[13] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 0, 32'h11223344, 1'b0, 2, 1, 30'h1, 4'b0000, 32'h0, 32'h11223344};

    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0;
    rs1 = '0; imm = '0; rs2_data = '0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done_err", {30'd0, done, err}, 32'h0);
    check("rst_req_we", {30'd0, mem_if.mem_req, mem_if.mem_we}, 32'h0);
    check("rst_addr", 32'(mem_if.mem_addr), 32'h0);
    check("rst_wstrb", 32'(mem_if.mem_wstrb), 32'h0);
    check("rst_wdata", mem_if.mem_wdata, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_cmd(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].k, vecs[i].rd);
      check($sformatf("v%0d_pulse_cycle", i), 32'(vecs[i].e_err ? r_err : r_done), 32'(vecs[i].e_cyc));
      check($sformatf("v%0d_no_other_pulse", i), 32'(vecs[i].e_err ? r_done : r_err), 32'hFFFFFFFF);
      check($sformatf("v%0d_idle_cycle", i), 32'(r_idle), 32'(vecs[i].e_cyc + 1));
      check($sformatf("v%0d_req_cycles", i), 32'(r_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req > 0) begin
        check($sformatf("v%0d_addr", i), 32'(r_addr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d_wstrb", i), 32'(r_wstrb), 32'(vecs[i].e_wstrb));
        check($sformatf("v%0d_we", i), 32'(r_we), 32'(vecs[i].st));
        if (vecs[i].st) check($sformatf("v%0d_wdata", i), r_wdata, vecs[i].e_wdata);
      end
      check($sformatf("v%0d_load_data", i), r_ld, vecs[i].e_ld);
    end

    // start while busy and in the DONE cycle must be ignored
    is_store = 1'b0; funct3 = 3'b010; rs1 = 32'h300; imm = 32'h0; start = 1'b1;
    mem_if.mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    nreq = 0; ndone = 0; nerr = 0; addr_ok = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      start = (c == 1 || c == 2 || c == 4);
      rs1   = 32'h400;
      if (mem_if.mem_req) begin
        nreq++;
        if (mem_if.mem_addr != 30'hC0) addr_ok = 1'b0;
      end
      mem_if.mem_ready = mem_if.mem_req && (c == 3);
      if (done) ndone++;
      if (err) nerr++;
      if (c == 5) check("busy_start_in_done_ignored", 32'(busy), 32'h0);
      @(posedge clk); #1;
    end
    start = 1'b0; mem_if.mem_ready = 1'b0;
    check("busy_req_cycles", 32'(nreq), 32'd3);
    check("busy_addr_held", 32'(addr_ok), 32'h1);
    check("busy_done_count", 32'(ndone), 32'd1);
    check("busy_err_count", 32'(nerr), 32'd0);
    check("busy_load_data", load_data, 32'h0BADF00D);

    // Synchronous reset in the middle of REQ
    is_store = 1'b0; funct3 = 3'b010; rs1 = 32'h500; imm = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_rst_req_before", 32'(mem_if.mem_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_req", 32'(mem_if.mem_req), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_load_data", load_data, 32'h0);
    ndone = 0; nerr = 0; nreq = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) ndone++;
      if (err) nerr++;
      if (mem_if.mem_req) nreq++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_pulse", 32'(ndone + nerr), 32'd0);
    check("mid_rst_no_req", 32'(nreq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
